router_register_core: RTL and testbench

//  Datapath register stage of the 1x3 packet router, between the input port and the three output FIFOs.
//  - Latches the header byte and forwards header, payload and parity bytes on dout under FSM state strobes.
//  - Holds one byte back while the FIFO is full.
//  - Computes a running XOR parity, compares it with the trailing parity byte, and flags error.

---
 rtl/router_pkg.sv | 7 +
 rtl/router_parity_chk.sv | 81 ++++++++
 rtl/router_register_core.sv | 76 +++++++
 tb/tb_router_register_core.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants: byte width and the destination-address field.
// The FSM, FIFO, sync and register blocks all use these.
package router_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity versus trailing parity byte; the error flag lags parity_done by one cycle.
// ROUTER_REG_STICKY_ERR_EN makes error sticky until the next detect_add or reset.
module router_parity_chk
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              pkt_vld,
  input  logic              fifo_full,
  input  logic              low_packet_valid,
  input  logic [DATA_W-1:0] hdr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] hold,
  output logic              parity_done,
  output logic              error
);

  logic [DATA_W-1:0] internal_parity;
  logic [DATA_W-1:0] packet_parity;
  logic              ld_last;
  logic              laf_capture;

  // The parity byte arrives either directly in LOAD_DATA, or from the hold register after a full stall.
  assign ld_last     = ld_state & ~pkt_vld & ~fifo_full;
  assign laf_capture = laf_state & low_packet_valid & ~parity_done;

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      internal_parity <= '0;
    else if (detect_add)
      internal_parity <= '0;
    else if (lfd_state && pkt_vld)
      internal_parity <= internal_parity ^ hdr;
    else if (ld_state && pkt_vld && !full_state)
      internal_parity <= internal_parity ^ data_in;
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      packet_parity <= '0;
    else if (detect_add)
      packet_parity <= '0;
    else if (ld_last)
      packet_parity <= data_in;
    else if (laf_capture)
      packet_parity <= hold;
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      parity_done <= 1'b0;
    else if (detect_add)
      parity_done <= 1'b0;
    else if (ld_last || laf_capture)
      parity_done <= 1'b1;
  end

`ifdef ROUTER_REG_STICKY_ERR_EN
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      error <= 1'b0;
    else if (detect_add)
      error <= 1'b0;
    else if (parity_done && (internal_parity != packet_parity))
      error <= 1'b1;
  end
`else
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      error <= 1'b0;
    else if (parity_done)
      error <= (internal_parity != packet_parity);
  end
`endif

endmodule

// File: rtl/router_register_core.sv
// Router register stage: header latch, one-cycle dout register, full-hold byte; parity check in router_parity_chk.
// A full FIFO parks one byte in hold until LOAD_AFTER_FULL; ROUTER_REG_STICKY_ERR_EN selects sticky error.
module router_register_core
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_vld,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] dout,
  output logic              error,
  output logic              parity_done,
  output logic              low_packet_valid
);

  logic [DATA_W-1:0] hdr;
  logic [DATA_W-1:0] hold;

  // Headers carrying the invalid address leave the previous header in place.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      hdr <= '0;
    else if (detect_add && pkt_vld && (data_in[ADDR_W-1:0] != ADDR_INVALID))
      hdr <= data_in;
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      dout <= '0;
      hold <= '0;
    end else if (lfd_state) begin
      dout <= hdr;
    end else if (ld_state && !fifo_full) begin
      dout <= data_in;
    end else if (ld_state && fifo_full) begin
      hold <= data_in;
    end else if (laf_state) begin
      dout <= hold;
    end
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      low_packet_valid <= 1'b0;
    else if (rst_int_reg)
      low_packet_valid <= 1'b0;
    else if (ld_state && !pkt_vld)
      low_packet_valid <= 1'b1;
  end

  router_parity_chk u_parity_chk (
    .clock            (clock),
    .resetn           (resetn),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .pkt_vld          (pkt_vld),
    .fifo_full        (fifo_full),
    .low_packet_valid (low_packet_valid),
    .hdr              (hdr),
    .data_in          (data_in),
    .hold             (hold),
    .parity_done      (parity_done),
    .error            (error)
  );

endmodule

// File: tb/tb_router_register_core.sv
// Directed bench for router_register_core: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_router_register_core;
  import router_pkg::*;

  logic              clock = 1'b0;
  logic              resetn = 1'b1;
  logic              pkt_vld = 1'b0;
  logic              fifo_full = 1'b0;
  logic              detect_add = 1'b0;
  logic              lfd_state = 1'b0;
  logic              ld_state = 1'b0;
  logic              laf_state = 1'b0;
  logic              full_state = 1'b0;
  logic              rst_int_reg = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] dout;
  logic              error;
  logic              parity_done;
  logic              low_packet_valid;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] dout;
    logic              err;
    logic              pd;
    logic              lpv;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  router_register_core dut (
    .clock            (clock),
    .resetn           (resetn),
    .pkt_vld          (pkt_vld),
    .fifo_full        (fifo_full),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .data_in          (data_in),
    .dout             (dout),
    .error            (error),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid)
  );

  // Monitor: one registered output set per clock, compared against the oldest expectation.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (dout === e.dout && error === e.err && parity_done === e.pd && low_packet_valid === e.lpv)
        n_pass++;
      else
        $display("FAIL %s: got dout=%02h err=%b pd=%b lpv=%b, expected dout=%02h err=%b pd=%b lpv=%b",
                 e.name, dout, error, parity_done, low_packet_valid, e.dout, e.err, e.pd, e.lpv);
    end
  end

  // Drive one cycle of strobes (flags = {rst,da,lfd,ld,laf,fs,rir,pv,ff}) and queue the post-edge outputs.
  task automatic step(input string nm, input logic [8:0] flags, input logic [7:0] din,
                      input logic [7:0] e_dout, input logic e_err, input logic e_pd, input logic e_lpv);
    exp_t e;
    @(negedge clock);
    {resetn, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, pkt_vld, fifo_full} = flags;
    data_in = din;
    @(posedge clock);
    e.name = nm; e.dout = e_dout; e.err = e_err; e.pd = e_pd; e.lpv = e_lpv;
    exp_q.push_back(e);
  endtask

  //                               rst da lfd ld laf fs rir pv ff
  localparam logic [8:0] RST  = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] IDLE = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] DET  = 9'b0_1_0_0_0_0_0_1_0;
  localparam logic [8:0] LFD  = 9'b0_0_1_0_0_0_0_1_0;
  localparam logic [8:0] LD   = 9'b0_0_0_1_0_0_0_1_0;
  localparam logic [8:0] LDP  = 9'b0_0_0_1_0_0_0_0_0;
  localparam logic [8:0] LDF  = 9'b0_0_0_1_0_0_0_1_1;
  localparam logic [8:0] LDPF = 9'b0_0_0_1_0_0_0_0_1;
  localparam logic [8:0] LAF  = 9'b0_0_0_0_1_0_0_1_0;
  localparam logic [8:0] LAFP = 9'b0_0_0_0_1_0_0_0_0;
  localparam logic [8:0] CHK  = 9'b0_0_0_0_0_0_1_0_0;

  initial begin
    step("reset",        RST,  8'h00, 8'h00, 0, 0, 0);

    // Good packet: hdr 0E, payload 11 22 33, parity 0E.
    step("good_det",     DET,  8'h0E, 8'h00, 0, 0, 0);
    step("good_lfd",     LFD,  8'h11, 8'h0E, 0, 0, 0);
    step("good_ld1",     LD,   8'h11, 8'h11, 0, 0, 0);
    step("good_ld2",     LD,   8'h22, 8'h22, 0, 0, 0);
    step("good_ld3",     LD,   8'h33, 8'h33, 0, 0, 0);
    step("good_par",     LDP,  8'h0E, 8'h0E, 0, 1, 1);
    step("good_chk",     CHK,  8'h00, 8'h0E, 0, 1, 0);

    // Bad parity byte 0F.
    step("bad_det",      DET,  8'h0E, 8'h0E, 0, 0, 0);
    step("bad_lfd",      LFD,  8'h11, 8'h0E, 0, 0, 0);
    step("bad_ld1",      LD,   8'h11, 8'h11, 0, 0, 0);
    step("bad_ld2",      LD,   8'h22, 8'h22, 0, 0, 0);
    step("bad_ld3",      LD,   8'h33, 8'h33, 0, 0, 0);
    step("bad_par",      LDP,  8'h0F, 8'h0F, 0, 1, 1);
    step("bad_chk",      CHK,  8'h00, 8'h0F, 1, 1, 0);
    step("bad_idle",     IDLE, 8'h00, 8'h0F, 1, 1, 0);

    // Invalid address 3 keeps hdr 0E; then a FIFO-full stall mid-payload.
    step("inv_det",      DET,  8'h0F, 8'h0F, 1, 0, 0);
    step("inv_lfd",      LFD,  8'h00, 8'h0E, 1, 0, 0);
    step("full_ld1",     LD,   8'h11, 8'h11, 1, 0, 0);
    step("full_stall",   LDF,  8'h22, 8'h11, 1, 0, 0);
    step("full_laf",     LAF,  8'h00, 8'h22, 1, 0, 0);
    step("full_ld3",     LD,   8'h33, 8'h33, 1, 0, 0);
    step("full_par",     LDP,  8'h0E, 8'h0E, 1, 1, 1);
    step("full_chk",     CHK,  8'h00, 8'h0E, 0, 1, 0);

    // Parity byte arrives while full: captured via hold in LOAD_AFTER_FULL. hdr 05, payload 44, parity 41.
    step("lpv_det",      DET,  8'h05, 8'h0E, 0, 0, 0);
    step("lpv_lfd",      LFD,  8'h44, 8'h05, 0, 0, 0);
    step("lpv_ld1",      LD,   8'h44, 8'h44, 0, 0, 0);
    step("lpv_parfull",  LDPF, 8'h41, 8'h44, 0, 0, 1);
    step("lpv_laf",      LAFP, 8'h00, 8'h41, 0, 1, 1);
    step("lpv_chk",      CHK,  8'h00, 8'h41, 0, 1, 0);

    // Reset mid-packet, then a clean good packet.
    step("mid_det",      DET,  8'h0E, 8'h41, 0, 0, 0);
    step("mid_lfd",      LFD,  8'h11, 8'h0E, 0, 0, 0);
    step("mid_ld1",      LD,   8'h11, 8'h11, 0, 0, 0);
    step("mid_reset",    RST,  8'h22, 8'h00, 0, 0, 0);
    step("re_det",       DET,  8'h0E, 8'h00, 0, 0, 0);
    step("re_lfd",       LFD,  8'h11, 8'h0E, 0, 0, 0);
    step("re_ld1",       LD,   8'h11, 8'h11, 0, 0, 0);
    step("re_ld2",       LD,   8'h22, 8'h22, 0, 0, 0);
    step("re_ld3",       LD,   8'h33, 8'h33, 0, 0, 0);
    step("re_par",       LDP,  8'h0E, 8'h0E, 0, 1, 1);
    step("re_chk",       CHK,  8'h00, 8'h0E, 0, 1, 0);

    @(negedge clock);
    {resetn, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, pkt_vld, fifo_full} = IDLE;
    repeat (3) @(negedge clock);
    n_checks++;
    if (exp_q.size() == 0)
      n_pass++;
    else
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
